bcd2bin_seq: RTL



---
 rtl/bcd2bin_seq.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/bcd2bin_seq.sv
`default_nettype none
// ============================================================================
// Module      : bcd2bin_seq
// Description : Sequential BCD-to-binary converter (reverse double-dabble).
//               Converts a three-digit BCD value (hundreds 0-7, tens, units)
//               into a 9-bit binary result plus an overflow flag for values
//               512..799. One shift/correct step is performed per clock,
//               behind a simple valid/ready handshake.
//
//               Each step shifts {bcd,bin} right by one bit. The BCD LSB
//               moves into the binary MSB. Any BCD digit that is then >= 8
//               has 3 subtracted from it.
//
// Ports       : clk         rising-edge clock
//               rst         asynchronous active-high reset
//               in_valid    input digits valid
//               in_hundred  BCD hundreds digit (3 bits, 0-7)
//               in_ten      BCD tens digit (4 bits)
//               in_unit     BCD units digit (4 bits)
//               in_ready    block idle, can accept a new input
//               out_valid   one-cycle result strobe
//               out_bin     binary result (value mod 512)
//               out_ovf     value > 511
//               out_err     illegal tens/units digit (0 unless enabled)
//
// Parameters  : BIN_W   width of out_bin (only 9 is supported)
//               N_ITER  number of CALC steps (>= 10)
//
// Options     : BCD2BIN_ERR_EN - when defined, tens or units digits > 9 are
//               flagged on out_err and force out_bin/out_ovf to 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module bcd2bin_seq #(
    parameter int BIN_W  = 9,
    parameter int N_ITER = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [2:0]       in_hundred,
    input  logic [3:0]       in_ten,
    input  logic [3:0]       in_unit,
    output logic             in_ready,
    output logic             out_valid,
    output logic [BIN_W-1:0] out_bin,
    output logic             out_ovf,
    output logic             out_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_BCD_W    = 11;          // 3 + 4 + 4 digit bits
    localparam int c_ACC_W    = BIN_W + 1;   // binary register incl. overflow bit
    localparam int c_DATA_BITS = 10;         // bit count of 799
    localparam int c_CNT_W    = $clog2(N_ITER + 1);

    // The binary register only holds c_DATA_BITS bits; steps beyond that are
    // counted but do not shift, so a larger N_ITER only stretches latency.
    localparam logic [c_CNT_W-1:0] c_SHIFT_END = c_CNT_W'(c_DATA_BITS);
    localparam logic [c_CNT_W-1:0] c_ITER_LAST = c_CNT_W'(N_ITER - 1);

    // FSM encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]                 r_state;
    logic [1:0]                 w_next_state;

    logic [c_BCD_W-1:0]         r_bcd;
    logic [c_ACC_W-1:0]         r_bin;
    logic [c_CNT_W-1:0]         r_cnt;

    logic                       r_out_valid;
    logic [BIN_W-1:0]           r_out_bin;
    logic                       r_out_ovf;
    logic                       r_out_err;

    logic                       w_in_ready;
    logic                       w_accept;
    logic                       w_calc;
    logic                       w_last_step;
    logic                       w_load_result;
    logic                       w_do_shift;

    logic [c_BCD_W+c_ACC_W-1:0] w_shifted;
    logic [c_BCD_W-1:0]         w_sh_bcd;
    logic [c_ACC_W-1:0]         w_sh_bin;
    logic [3:0]                 w_ten_adj;
    logic [3:0]                 w_unit_adj;
    logic [c_BCD_W-1:0]         w_bcd_next;
    logic                       w_err_in;
    logic                       w_err_res;

    // ------------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------------
    assign w_accept    = in_valid & w_in_ready;
    assign w_calc      = (r_state == c_ST_CALC);
    assign w_last_step = w_calc & (r_cnt == c_ITER_LAST);
    assign w_do_shift  = (r_cnt < c_SHIFT_END);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (in_valid) begin
                    w_next_state = c_ST_CALC;
                end
            end
            c_ST_CALC: begin
                if (r_cnt == c_ITER_LAST) begin
                    w_next_state = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output decode
    // in_ready is purely a function of the state, so it is already high in
    // the cycle where out_valid is presented; that is what allows a new
    // input to be taken at the edge that ends the result strobe.
    // ------------------------------------------------------------------------
    always_comb begin
        w_in_ready    = 1'b0;
        w_load_result = 1'b0;
        case (r_state)
            c_ST_IDLE: w_in_ready    = 1'b1;
            c_ST_DONE: w_load_result = 1'b1;
            default: begin
                w_in_ready    = 1'b0;
                w_load_result = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Reverse double-dabble step
    // The hundreds field is only 3 bits wide and can never reach 8 after a
    // right shift, so only the tens and units digits need correction. The
    // tens MSB is fed by the hundreds LSB, and the units MSB by the tens LSB.
    // ------------------------------------------------------------------------
    assign w_shifted = {r_bcd, r_bin} >> 1;
    assign w_sh_bcd  = w_shifted[c_BCD_W+c_ACC_W-1:c_ACC_W];
    assign w_sh_bin  = w_shifted[c_ACC_W-1:0];

    always_comb begin
        w_ten_adj  = w_sh_bcd[7:4];
        w_unit_adj = w_sh_bcd[3:0];
        if (w_sh_bcd[7:4] >= 4'd8) begin
            w_ten_adj = w_sh_bcd[7:4] - 4'd3;
        end
        if (w_sh_bcd[3:0] >= 4'd8) begin
            w_unit_adj = w_sh_bcd[3:0] - 4'd3;
        end
    end

    assign w_bcd_next = {w_sh_bcd[10:8], w_ten_adj, w_unit_adj};

    // ------------------------------------------------------------------------
    // Datapath registers: BCD/binary shift pair and step counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcd <= '0;
            r_bin <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_bcd <= {in_hundred, in_ten, in_unit};
            r_bin <= '0;
            r_cnt <= '0;
        end else if (w_calc) begin
            if (w_do_shift) begin
                r_bcd <= w_bcd_next;
                r_bin <= w_sh_bin;
            end
            // Counter is cleared on the next accept; it only needs to be
            // valid while in CALC.
            if (!w_last_step) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Illegal-digit detection
    // ------------------------------------------------------------------------
    assign w_err_in = (in_ten > 4'd9) | (in_unit > 4'd9);

`ifdef BCD2BIN_ERR_EN
    logic r_err;

    // Captured at accept, since the input digits are not held by the source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_err_in;
        end
    end

    assign w_err_res = r_err;
`else
    // Detection is not used in this build; fold it away.
    logic w_err_unused;
    assign w_err_unused = w_err_in;
    assign w_err_res    = 1'b0 & w_err_unused;
`endif

    // ------------------------------------------------------------------------
    // Result registers
    // Result fields hold their value between conversions; only the strobe
    // returns to zero.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_bin   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            r_out_valid <= w_load_result;
            if (w_load_result) begin
                if (w_err_res) begin
                    r_out_bin <= '0;
                    r_out_ovf <= 1'b0;
                end else begin
                    r_out_bin <= r_bin[BIN_W-1:0];
                    r_out_ovf <= r_bin[BIN_W];
                end
                r_out_err <= w_err_res;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_bin   = r_out_bin;
    assign out_ovf   = r_out_ovf;
    assign out_err   = r_out_err;

endmodule
`default_nettype wire
